// File: rtl/score_display.sv
// Drives a 4-digit multiplexed 7-segment display with a right-aligned decimal score (0..15).
// Optional post-change flash effect is enabled by defining SCORE_FLASH_EN.
module score_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int FLASH_DIV    = 25000000,
  parameter int FLASH_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] CURRENT_SCORE,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] DEC_OUT
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    score_q;
  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    sel_d;
  logic [7:0]    dec_d;
  logic          flash_blank;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

`ifdef SCORE_FLASH_EN
  localparam int FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int FPW = $clog2(2 * FLASH_CYCLES);
  localparam logic [FCW-1:0] FCNT_LAST  = FCW'(FLASH_DIV - 1);
  localparam logic [FPW-1:0] FPHASE_LAST = FPW'(2 * FLASH_CYCLES - 1);

  logic           flash_active;
  logic [FPW-1:0] flash_phase;
  logic [FCW-1:0] flash_cnt;

  // A score change restarts the flash; a change to zero cancels it outright.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flash_active <= 1'b0;
      flash_phase  <= '0;
      flash_cnt    <= '0;
    end else if (CURRENT_SCORE != score_q) begin
      flash_active <= (CURRENT_SCORE != 4'd0);
      flash_phase  <= '0;
      flash_cnt    <= '0;
    end else if (flash_active) begin
      if (flash_cnt == FCNT_LAST) begin
        flash_cnt <= '0;
        if (flash_phase == FPHASE_LAST) flash_active <= 1'b0;
        else flash_phase <= flash_phase + FPW'(1);
      end else begin
        flash_cnt <= flash_cnt + FCW'(1);
      end
    end
  end

  // Even phases are the blank ones.
  assign flash_blank = flash_active && !flash_phase[0];
`else
  assign flash_blank = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tens  = (score_q >= 4'd10);
    ones  = tens ? (score_q - 4'd10) : score_q;
    sel_d = 4'b1111;
    dec_d = 8'hFF;
    if (!flash_blank) begin
      case (idx)
        2'd0: begin
          sel_d = 4'b1110;
          dec_d = seg7(ones);
        end
        2'd1: begin
          if (tens) begin
            sel_d = 4'b1101;
            dec_d = seg7(4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RESET) begin
      presc      <= '0;
      idx        <= '0;
      score_q    <= '0;
      SEG_SELECT <= 4'b1111;
      DEC_OUT    <= 8'hFF;
    end else begin
      score_q    <= CURRENT_SCORE;
      SEG_SELECT <= sel_d;
      DEC_OUT    <= dec_d;
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: per-cycle reference model plus literal spot checks.
// Define SCORE_FLASH_EN for both RTL and bench to cover the flash variant.
module tb_score_display;

  localparam int RD = 4;
  localparam int FD = 8;
  localparam int FC = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] CURRENT_SCORE = 4'd0;
  logic [3:0] SEG_SELECT;
  logic [7:0] DEC_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  score_display #(.REFRESH_DIV(RD), .FLASH_DIV(FD), .FLASH_CYCLES(FC)) dut (
    .CLK(CLK), .RESET(RESET), .CURRENT_SCORE(CURRENT_SCORE),
    .SEG_SELECT(SEG_SELECT), .DEC_OUT(DEC_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: output after each edge follows from the count of cycles since
  // reset release and the score sampled one edge earlier, using decimal arithmetic.
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         n_rel = 0;
  int         sq = 0;
  int         fl_age = -1;
  int         slot;
  logic [3:0] exp_sel = 4'b1111;
  logic [7:0] exp_dec = 8'hFF;
  bit         armed = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      exp_sel = 4'b1111;
      exp_dec = 8'hFF;
      n_rel   = 0;
      sq      = 0;
      fl_age  = -1;
      armed   = 1'b1;
    end else begin
      slot    = (n_rel / RD) % 4;
      exp_sel = 4'b1111;
      exp_dec = 8'hFF;
      if (slot == 0) begin
        exp_sel = 4'b1110;
        exp_dec = seg_tab[sq % 10];
      end else if (slot == 1 && sq >= 10) begin
        exp_sel = 4'b1101;
        exp_dec = seg_tab[sq / 10];
      end
`ifdef SCORE_FLASH_EN
      if (fl_age >= 0 && fl_age < 2 * FC * FD && ((fl_age / FD) % 2) == 0) begin
        exp_sel = 4'b1111;
        exp_dec = 8'hFF;
      end
      if (int'(CURRENT_SCORE) != sq) fl_age = (CURRENT_SCORE != 4'd0) ? 0 : -1;
      else if (fl_age >= 0) fl_age = (fl_age + 1 >= 2 * FC * FD) ? -1 : fl_age + 1;
`endif
      n_rel++;
      sq = int'(CURRENT_SCORE);
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      check("model_sel", 32'(SEG_SELECT), 32'(exp_sel));
      check("model_dec", 32'(DEC_OUT), 32'(exp_dec));
      check("one_anode", 32'($countones(~SEG_SELECT) <= 1), 32'd1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Waits (bounded) until SEG_SELECT equals / differs from v, sampling on negedges.
  task automatic wait_sel(input string name, input logic [3:0] v, input bit eq);
    bit found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge CLK);
      if ((SEG_SELECT == v) == eq) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    // Reset held for 5 cycles.
    RESET = 1'b1;
    CURRENT_SCORE = 4'd0;
    cycles(5);
    check("reset_sel", 32'(SEG_SELECT), 32'h F);
    check("reset_dec", 32'(DEC_OUT), 32'h FF);
    RESET = 1'b0;
    cycles(1);
    check("rel_sel", 32'(SEG_SELECT), 32'b1110);
    check("rel_dec", 32'(DEC_OUT), 32'h C0);
    cycles(4);
    check("rel_blank_sel", 32'(SEG_SELECT), 32'h F);
    cycles(28);

    // Steady single digit.
    CURRENT_SCORE = 4'd7;
    cycles(40);
    wait_sel("w7_ones", 4'b1110, 1'b1);
    check("s7_dec", 32'(DEC_OUT), 32'h F8);

    // Two digits.
    CURRENT_SCORE = 4'd12;
    cycles(40);
    wait_sel("w12_tens", 4'b1101, 1'b1);
    check("s12_tens_dec", 32'(DEC_OUT), 32'h F9);
    wait_sel("w12_ones", 4'b1110, 1'b1);
    check("s12_ones_dec", 32'(DEC_OUT), 32'h A4);

    // Wrap 15 -> 0 at the start of a ones slot.
    CURRENT_SCORE = 4'd15;
    cycles(40);
    wait_sel("w15_out", 4'b1110, 1'b0);
    wait_sel("w15_in", 4'b1110, 1'b1);
    check("s15_dec", 32'(DEC_OUT), 32'h 92);
    CURRENT_SCORE = 4'd0;
    cycles(1);
    check("wrap_lag_dec", 32'(DEC_OUT), 32'h 92);
    cycles(1);
    check("wrap_dec", 32'(DEC_OUT), 32'h C0);
    cycles(20);

    // One-cycle reset pulse in the tens slot.
    CURRENT_SCORE = 4'd12;
    cycles(40);
    wait_sel("wrst_tens", 4'b1101, 1'b1);
    RESET = 1'b1;
    cycles(1);
    check("rst_mid_sel", 32'(SEG_SELECT), 32'h F);
    check("rst_mid_dec", 32'(DEC_OUT), 32'h FF);
    RESET = 1'b0;
    cycles(1);
    check("rst_idx0_sel", 32'(SEG_SELECT), 32'b1110);
    check("rst_idx0_dec", 32'(DEC_OUT), 32'h C0);
    cycles(1);
`ifdef SCORE_FLASH_EN
    check("rst_after_dec", 32'(DEC_OUT), 32'h FF);
`else
    check("rst_after_dec", 32'(DEC_OUT), 32'h A4);
`endif
    cycles(40);

    // Sweep every score value.
    for (int s = 0; s < 16; s++) begin
      CURRENT_SCORE = 4'(s);
      cycles(2 * RD * 4 + 3);
    end

    // Flash scenarios (model tracks them when the variant is enabled).
    CURRENT_SCORE = 4'd3;
    cycles(40);
    CURRENT_SCORE = 4'd4;
    cycles(45);
    CURRENT_SCORE = 4'd5;
    cycles(10);
    CURRENT_SCORE = 4'd6;
    cycles(5);
    CURRENT_SCORE = 4'd0;
    cycles(40);

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
